maze_loader: RTL and testbench
==============================

# maze_loader

Upstream feeder for the rat-in-maze solver: accepts the maze bitmap one row per valid/ready handshake, serialises each row into single-cell writes on the maze memory write port, then releases the solver's `start`. Holds the solver off until a complete maze is resident. Sits between the host/testbench stimulus and the solver top.

## Interface
Parameters:
- `ROWS`, 16, maze rows
- `COLS`, 16, maze columns (power of two)
- `LOC_W`, 8, memory address width, equal to log2(ROWS*COLS)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load`  in  1  pulse; begins a new maze load
- `rowValid`  in  1  `rowData` valid
- `rowData`  in  COLS  one maze row; bit c = cell (row, c), 1 = wall
- `rowReady`  out  1  loader can accept a row
- `memLoc`  out  LOC_W  write address to maze memory
- `memDIn`  out  1  cell value to write
- `memWr`  out  1  write strobe, one cell per cycle
- `startReq`  in  1  external request to start the solver
- `start`  out  1  one-cycle start pulse to the solver
- `busy`  out  1  load in progress
- `loaded`  out  1  a complete maze is resident

## Operation
- States: IDLE, WAIT_ROW, WRITE, DONE.
- IDLE: `rowReady`=0. `load`=1 -> WAIT_ROW, row counter = 0, `loaded` cleared.
- WAIT_ROW: `rowReady`=1. Handshake (`rowValid`&&`rowReady`) latches `rowData` into a shift register, column counter = 0 -> WRITE.
- WRITE: `memWr`=1, `memLoc`={row,col} (= row*COLS+col), `memDIn`=rowData[col]. Column counter increments each cycle. At col=COLS-1: if row=ROWS-1 -> DONE, otherwise row+1 -> WAIT_ROW.
- DONE: `loaded`=1. `load`=1 -> WAIT_ROW, row 0, `loaded`=0 (reload).
- `start`: registered one-cycle pulse when `startReq`=1 and `loaded`=1. Asserting `startReq` while `loaded`=0 has no effect (no deferred start). Holding `startReq` high produces a single pulse (rising-edge detect).
- `busy`=1 in WAIT_ROW and WRITE.
- `load` is ignored in WAIT_ROW and WRITE.
- `rowValid` is ignored in IDLE, WRITE and DONE. The row is not consumed.
- Row and column counters are sized log2(ROWS) and log2(COLS). They never wrap past ROWS-1 or COLS-1. The terminal comparisons are exact.

## Timing
- Reset values: `rowReady`=0, `memWr`=0, `memLoc`=0, `memDIn`=0, `start`=0, `busy`=0, `loaded`=0. State = IDLE.
- `load` at cycle t -> `rowReady`=1 at t+1.
- Row handshake at t -> first write at t+1 and last write at t+COLS. `rowReady` is high again at t+COLS+1.
- Full maze: minimum ROWS*(COLS+1)+1 cycles from `load` to `loaded`=1. This is 273 cycles for 16x16.
- `startReq` rising at t with `loaded`=1 -> `start`=1 at t+1 only.
- Reset mid-load: all outputs return to reset values immediately (asynchronous). Partially written memory is left as is. `loaded`=0 guarantees the solver is not started.

## Configuration
- `MAZE_AUTO_START_EN` defined: `start` also pulses for one cycle on the cycle after entering DONE, with no `startReq` needed. A `startReq` in that same cycle still yields only one pulse.
- Macro undefined: `start` is produced only from `startReq` as above.

## Structure
- Shared package `maze_pkg`: `ROWS`, `COLS`, `LOC_W` constants and the loader state enum (IDLE, WAIT_ROW, WRITE, DONE). The solver shares the same maze dimensions.
- One sub-module, `maze_row_shifter`: COLS-bit load/shift register plus column counter. It raises `last` at col=COLS-1.
- FSM and row counter live in `maze_loader`.

## Test plan
- Reset, then `load`, then 16 rows of alternating 16'hAAAA / 16'h5555 with `rowValid` held high -> 256 writes, `memLoc` 0..255 in order, `memDIn`=rowData[col]. `loaded`=1 at cycle 273 after `load`.
- `rowValid` toggled randomly -> `rowReady` seen only in WAIT_ROW. No row is lost or duplicated. Memory image matches the stimulus.
- `startReq` before load completes -> no `start`. `startReq` held high after `loaded` -> exactly one `start` pulse, one cycle after the rise.
- `rst` driven low during row 7, cell 5 -> `memWr`/`busy`/`loaded` drop to 0 immediately. A new `load` restarts at `memLoc`=0.
- `load` pulsed during WRITE -> ignored. `load` in DONE -> `loaded`=0 and the reload writes all 256 cells again.
- With `MAZE_AUTO_START_EN`: full load -> `start`=1 for one cycle right after `loaded` rises. Without the macro: no `start` until `startReq`.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze dimensions and loader state encoding, used by the loader and the
// solver so both agree on the maze geometry.
package maze_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int LOC_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } loader_state_e;

endpackage

// File: rtl/maze_row_shifter.sv
// Holds one maze row and presents it one cell per cycle, lowest column first,
// together with the current column index and a last-column flag.
module maze_row_shifter #(
  parameter  int COLS  = maze_pkg::COLS,
  localparam int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [COLS-1:0]  din,
  input  logic             shift,
  output logic             bit_out,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [COLS-1:0]  shreg_r;
  logic [COL_W-1:0] col_r;

  // Capture a new row, or step one cell toward bit 0; the column stops at COLS-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= {COLS{1'b0}};
      col_r   <= {COL_W{1'b0}};
    end else if (ld) begin
      shreg_r <= din;
      col_r   <= {COL_W{1'b0}};
    end else if (shift && (col_r != COL_LAST)) begin
      shreg_r <= {1'b0, shreg_r[COLS-1:1]};
      col_r   <= col_r + COL_W'(1);
    end
  end

  assign bit_out = shreg_r[0];
  assign col     = col_r;
  assign last    = (col_r == COL_LAST);

endmodule

// File: rtl/maze_loader.sv
// Maze loader: accepts the maze one row per handshake, writes it cell by cell
// into the maze memory, and only lets the solver start once a complete maze is
// resident.
// Optional feature: define MAZE_AUTO_START_EN to also pulse start once, right
// after a load completes, without needing startReq.
module maze_loader
  import maze_pkg::*;
#(
  parameter int ROWS  = maze_pkg::ROWS,
  parameter int COLS  = maze_pkg::COLS,
  parameter int LOC_W = maze_pkg::LOC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             rowValid,
  input  logic [COLS-1:0]  rowData,
  output logic             rowReady,
  output logic [LOC_W-1:0] memLoc,
  output logic             memDIn,
  output logic             memWr,
  input  logic             startReq,
  output logic             start,
  output logic             busy,
  output logic             loaded
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  loader_state_e    state_r;
  logic [ROW_W-1:0] row_cnt_r;
  logic [COL_W-1:0] col_s;
  logic             last_s;
  logic             handshake_s;
  logic             shift_s;
  logic             start_req_q_r;
  logic             auto_start_s;

  assign handshake_s = (state_r == WAIT_ROW) && rowValid && rowReady;
  assign shift_s     = (state_r == WRITE);
  assign memLoc      = {row_cnt_r, col_s};

  maze_row_shifter #(
    .COLS (COLS)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .ld      (handshake_s),
    .din     (rowData),
    .shift   (shift_s),
    .bit_out (memDIn),
    .col     (col_s),
    .last    (last_s)
  );

  // Loader FSM: sequences rows into cell writes, owns the row counter and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      row_cnt_r <= {ROW_W{1'b0}};
      rowReady  <= 1'b0;
      memWr     <= 1'b0;
      busy      <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (load) begin
            state_r   <= WAIT_ROW;
            row_cnt_r <= {ROW_W{1'b0}};
            rowReady  <= 1'b1;
            busy      <= 1'b1;
            loaded    <= 1'b0;
          end
        end
        WAIT_ROW: begin
          if (handshake_s) begin
            state_r  <= WRITE;
            rowReady <= 1'b0;
            memWr    <= 1'b1;
          end
        end
        WRITE: begin
          if (last_s) begin
            memWr <= 1'b0;
            if (row_cnt_r == ROW_LAST) begin
              state_r <= DONE;
              busy    <= 1'b0;
              loaded  <= 1'b1;
            end else begin
              row_cnt_r <= row_cnt_r + ROW_W'(1);
              state_r   <= WAIT_ROW;
              rowReady  <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          row_cnt_r <= {ROW_W{1'b0}};
          rowReady  <= 1'b0;
          memWr     <= 1'b0;
          busy      <= 1'b0;
          loaded    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAZE_AUTO_START_EN
  logic done_entry_r;

  // Mark the first cycle spent in DONE so start fires on the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_entry_r <= 1'b0;
    end else begin
      done_entry_r <= (state_r == WRITE) && last_s && (row_cnt_r == ROW_LAST);
    end
  end

  assign auto_start_s = done_entry_r;
`else
  assign auto_start_s = 1'b0;
`endif

  // One-cycle start on a startReq rising edge while a full maze is resident
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_req_q_r <= 1'b0;
      start         <= 1'b0;
    end else begin
      start_req_q_r <= startReq;
      start         <= (startReq && !start_req_q_r && loaded) || auto_start_s;
    end
  end

endmodule

// File: tb/tb_maze_loader.sv
// Self-checking bench for maze_loader: random and patterned mazes are fed in,
// every memory write is logged, and the log is compared against the expected
// cell order, values and cycle positions derived from the row stimulus.
module tb_maze_loader;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int LOC_W = 8;
  localparam int CELLS = ROWS * COLS;
  localparam int FULL_CYC = ROWS * (COLS + 1) + 1;
`ifdef MAZE_AUTO_START_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             rowValid = 1'b0;
  logic [COLS-1:0]  rowData = 16'h0000;
  logic             startReq = 1'b0;
  logic             rowReady;
  logic [LOC_W-1:0] memLoc;
  logic             memDIn;
  logic             memWr;
  logic             start;
  logic             busy;
  logic             loaded;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;
  int bad_ready = 0;

  logic [COLS-1:0] rows [0:ROWS-1];
  int wr_loc[$];
  bit wr_din[$];
  int wr_cyc[$];
  int st_cyc[$];

  maze_loader dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .rowValid (rowValid),
    .rowData  (rowData),
    .rowReady (rowReady),
    .memLoc   (memLoc),
    .memDIn   (memDIn),
    .memWr    (memWr),
    .startReq (startReq),
    .start    (start),
    .busy     (busy),
    .loaded   (loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log writes and start pulses mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (memWr) begin
      wr_loc.push_back(int'(memLoc));
      wr_din.push_back(memDIn);
      wr_cyc.push_back(cyc);
    end
    if (start) st_cyc.push_back(cyc);
    if (rowReady && (memWr || !busy || loaded)) bad_ready++;
  end

  task automatic clear_log();
    wr_loc.delete();
    wr_din.delete();
    wr_cyc.delete();
    st_cyc.delete();
    bad_ready = 0;
  endtask

  // Number of logged writes that differ from row-major order over rows[]
  function automatic int bad_writes();
    int b = 0;
    for (int k = 0; k < wr_loc.size(); k++) begin
      if (k >= CELLS) b++;
      else if (wr_loc[k] != k || wr_din[k] != rows[k / COLS][k % COLS]) b++;
    end
    return b;
  endfunction

  // Number of writes off the back-to-back schedule: each row takes COLS+1 cycles
  function automatic int bad_timing();
    int b = 0;
    for (int k = 0; k < wr_cyc.size(); k++) begin
      if (wr_cyc[k] - base + 1 != 2 + (COLS + 1) * (k / COLS) + (k % COLS)) b++;
    end
    return b;
  endfunction

  // Pulse load, then feed rows until loaded; lidx is the cycle index of loaded (1 = cycle after load)
  task automatic drive_maze(input bit rand_valid, input bit poke_load, input int req_mode,
                            output int lidx, output bit ready1, output bit loaded1);
    int  ri;
    bit  hs;
    ri   = 0;
    lidx = -1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    base = cyc;
    ready1  = rowReady;
    loaded1 = loaded;
    if (req_mode == 2) startReq = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      if (loaded) begin
        lidx = k;
        break;
      end
      rowValid = (ri < ROWS) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      rowData  = (ri < ROWS) ? rows[ri] : 16'h0000;
      load     = poke_load && busy && ($urandom_range(0, 3) == 0);
      if (req_mode == 1) startReq = ($urandom_range(0, 1) == 1);
      hs = rowReady && rowValid;
      @(posedge clk); #1;
      if (hs) ri++;
    end
    load     = 1'b0;
    rowValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (rowReady !== 1'b0) begin fails++; $display("FAIL reset_rowReady got %b want 0", rowReady); end
    tests++; if (memWr !== 1'b0) begin fails++; $display("FAIL reset_memWr got %b want 0", memWr); end
    tests++; if (memLoc !== 8'd0) begin fails++; $display("FAIL reset_memLoc got %0d want 0", memLoc); end
    tests++; if (memDIn !== 1'b0) begin fails++; $display("FAIL reset_memDIn got %b want 0", memDIn); end
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (loaded !== 1'b0) begin fails++; $display("FAIL reset_loaded got %b want 0", loaded); end
    rst = 1'b1;
    rowValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rowValid = 1'b0;
    tests++; if (rowReady !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_no_ready got ready=%b busy=%b want 0/0", rowReady, busy); end
  endtask

  task automatic test_full_load();
    int lidx; bit r1; bit l1; int first_st;
    for (int r = 0; r < ROWS; r++) rows[r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
    clear_log();
    drive_maze(1'b0, 1'b0, 0, lidx, r1, l1);
    tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL full_ready_t1 got %b want 1", r1); end
    tests++; if (lidx != FULL_CYC) begin fails++; $display("FAIL full_loaded_cycle got %0d want %0d", lidx, FULL_CYC); end
    tests++; if (wr_loc.size() != CELLS) begin fails++; $display("FAIL full_write_count got %0d want %0d", wr_loc.size(), CELLS); end
    tests++; if (bad_writes() != 0) begin fails++; $display("FAIL full_write_data got %0d bad want 0", bad_writes()); end
    tests++; if (bad_timing() != 0) begin fails++; $display("FAIL full_write_timing got %0d bad want 0", bad_timing()); end
    tests++; if (st_cyc.size() != 0) begin fails++; $display("FAIL full_no_early_start got %0d pulses want 0", st_cyc.size()); end
    repeat (4) @(posedge clk);
    #1;
    first_st = (st_cyc.size() > 0) ? st_cyc[0] - base + 1 : -1;
    tests++; if (st_cyc.size() != (AUTO ? 1 : 0)) begin fails++; $display("FAIL auto_start_count got %0d want %0d", st_cyc.size(), AUTO ? 1 : 0); end
    tests++; if (first_st != (AUTO ? FULL_CYC + 1 : -1)) begin fails++; $display("FAIL auto_start_cycle got %0d want %0d", first_st, AUTO ? FULL_CYC + 1 : -1); end
  endtask

  task automatic test_random_valid();
    int lidx; bit r1; bit l1;
    for (int r = 0; r < ROWS; r++) rows[r] = 16'($urandom);
    clear_log();
    drive_maze(1'b1, 1'b0, 1, lidx, r1, l1);
    tests++; if (lidx < FULL_CYC) begin fails++; $display("FAIL rand_loaded_cycle got %0d want >= %0d", lidx, FULL_CYC); end
    tests++; if (wr_loc.size() != CELLS) begin fails++; $display("FAIL rand_write_count got %0d want %0d", wr_loc.size(), CELLS); end
    tests++; if (bad_writes() != 0) begin fails++; $display("FAIL rand_write_data got %0d bad want 0", bad_writes()); end
    tests++; if (bad_ready != 0) begin fails++; $display("FAIL rand_ready_outside_wait got %0d want 0", bad_ready); end
    tests++; if (st_cyc.size() != 0) begin fails++; $display("FAIL rand_start_before_loaded got %0d pulses want 0", st_cyc.size()); end
    startReq = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_start_req();
    int c;
    startReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st_cyc.delete();
    startReq = 1'b1;
    c = cyc;
    repeat (10) @(posedge clk);
    #1;
    tests++; if (st_cyc.size() != 1) begin fails++; $display("FAIL start_held_count got %0d want 1", st_cyc.size()); end
    tests++; if (st_cyc.size() == 0 || st_cyc[0] != c + 1) begin fails++; $display("FAIL start_pulse_cycle got %0d want %0d", (st_cyc.size() > 0) ? st_cyc[0] : -1, c + 1); end
    startReq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reload_ignore_load();
    int lidx; bit r1; bit l1;
    for (int r = 0; r < ROWS; r++) rows[r] = 16'($urandom);
    clear_log();
    drive_maze(1'b0, 1'b1, 2, lidx, r1, l1);
    tests++; if (l1 !== 1'b0) begin fails++; $display("FAIL reload_clears_loaded got %b want 0", l1); end
    tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL reload_ready got %b want 1", r1); end
    tests++; if (lidx != FULL_CYC) begin fails++; $display("FAIL reload_loaded_cycle got %0d want %0d", lidx, FULL_CYC); end
    tests++; if (wr_loc.size() != CELLS) begin fails++; $display("FAIL reload_write_count got %0d want %0d", wr_loc.size(), CELLS); end
    tests++; if (bad_writes() != 0) begin fails++; $display("FAIL reload_write_data got %0d bad want 0", bad_writes()); end
    tests++; if (bad_timing() != 0) begin fails++; $display("FAIL reload_write_timing got %0d bad want 0", bad_timing()); end
    repeat (4) @(posedge clk);
    #1;
    tests++; if (st_cyc.size() != (AUTO ? 1 : 0)) begin fails++; $display("FAIL held_req_no_deferred got %0d pulses want %0d", st_cyc.size(), AUTO ? 1 : 0); end
    startReq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int ri; bit hs; bit hit; int lidx; bit r1; bit l1;
    for (int r = 0; r < ROWS; r++) rows[r] = 16'($urandom);
    ri = 0;
    hit = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (memWr && memLoc == 8'd117) begin
        hit = 1'b1;
        break;
      end
      rowValid = (ri < ROWS);
      rowData  = (ri < ROWS) ? rows[ri] : 16'h0000;
      hs = rowReady && rowValid;
      @(posedge clk); #1;
      if (hs) ri++;
    end
    rowValid = 1'b0;
    tests++; if (!hit) begin fails++; $display("FAIL mid_reach_row7_cell5 got timeout want write of cell 117"); end
    rst = 1'b0;
    #1;
    tests++; if (memWr !== 1'b0) begin fails++; $display("FAIL mid_rst_memWr got %b want 0", memWr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    tests++; if (loaded !== 1'b0) begin fails++; $display("FAIL mid_rst_loaded got %b want 0", loaded); end
    tests++; if (memLoc !== 8'd0) begin fails++; $display("FAIL mid_rst_memLoc got %0d want 0", memLoc); end
    tests++; if (rowReady !== 1'b0) begin fails++; $display("FAIL mid_rst_rowReady got %b want 0", rowReady); end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_log();
    drive_maze(1'b0, 1'b0, 0, lidx, r1, l1);
    tests++; if (wr_loc.size() == 0 || wr_loc[0] != 0) begin fails++; $display("FAIL mid_restart_loc got %0d want 0", (wr_loc.size() > 0) ? wr_loc[0] : -1); end
    tests++; if (lidx != FULL_CYC) begin fails++; $display("FAIL mid_restart_loaded_cycle got %0d want %0d", lidx, FULL_CYC); end
    tests++; if (bad_writes() != 0 || wr_loc.size() != CELLS) begin fails++; $display("FAIL mid_restart_writes got %0d bad of %0d want 0 of %0d", bad_writes(), wr_loc.size(), CELLS); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_random_valid();
    test_start_req();
    test_reload_ignore_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
